// File: rtl/prbs_multi_gen.sv
// Multi-lane PRBS7/9/15/23/31 generator on a valid/ready stream.
// Ports: clk, rst (async, active-high); mode/start/stop/err_inject control;
//   out_valid/out_ready/data_out stream; busy and word_count status.
// Optional feature: define PRBS_ERR_INJ_EN to enable one-shot error injection.
module prbs_multi_gen #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_LANES   = 1,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [2:0]                      mode,
   input  logic                            start,
   input  logic                            stop,
   input  logic                            err_inject,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
   output logic                            busy,
   output logic [COUNT_WIDTH-1:0]          word_count
);

   localparam int DW = DATA_WIDTH;
   localparam int NL = NUM_LANES;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       mode_q;
   logic [2:0]       msel;
   logic [4:0]       tap_hi, tap_lo;
   logic             inv;
   logic [30:0]      lfsr_q [NL];
   logic [30:0]      lfsr_d [NL];
   logic [30:0]      s;
   logic             fb;
   logic [NL*DW-1:0] data_q, word_d, err_mask;
   logic [COUNT_WIDTH-1:0] cnt_q;
   logic             load, seed, count_en, accept;

   assign accept     = out_valid && out_ready;
   assign out_valid  = (state_q != IDLE);
   assign busy       = (state_q != IDLE);
   assign data_out   = data_q;
   assign word_count = cnt_q;

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      seed     = 1'b0;
      count_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = RUN;
               load    = 1'b1;
               seed    = 1'b1;
            end
         end
         RUN: begin
            if (accept) begin
               count_en = 1'b1;
               if (stop) state_d = IDLE;
               else      load    = 1'b1;
            end else if (stop) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (accept) begin
               count_en = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A start uses the live mode input; otherwise the latched one.
   assign msel = seed ? mode : mode_q;

   // Tap indices are (W-1, T-1); long patterns are sent inverted.
   always_comb begin
      tap_hi = 5'd30;
      tap_lo = 5'd27;
      inv    = 1'b1;
      unique case (msel)
         3'd0: begin tap_hi = 5'd6;  tap_lo = 5'd5;  inv = 1'b0; end
         3'd1: begin tap_hi = 5'd8;  tap_lo = 5'd4;  inv = 1'b0; end
         3'd2: begin tap_hi = 5'd14; tap_lo = 5'd13; end
         3'd3: begin tap_hi = 5'd22; tap_lo = 5'd17; end
         default: ;
      endcase
   end

   // Full word of DW steps per lane; first step lands in the lane MSB.
   always_comb begin
      word_d = '0;
      s      = '0;
      fb     = 1'b0;
      for (int i = 0; i < NL; i++) begin
         s = seed ? (31'h7FFFFFFF ^ 31'(i)) : lfsr_q[i];
         for (int b = DW - 1; b >= 0; b--) begin
            fb = s[tap_hi] ^ s[tap_lo];
            s  = {s[29:0], fb};
            word_d[i*DW + b] = fb ^ inv;
         end
         lfsr_d[i] = s;
      end
   end

`ifdef PRBS_ERR_INJ_EN
   logic err_arm_q;
   logic flip;

   // A pulse arriving with the load itself is honoured directly.
   assign flip = seed ? err_inject : (err_arm_q | err_inject);

   always_comb begin
      err_mask         = '0;
      err_mask[DW-1]   = flip;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              err_arm_q <= 1'b0;
      else if (load)        err_arm_q <= 1'b0;
      else if (err_inject)  err_arm_q <= 1'b1;
   end
`else
   logic unused_err;
   assign unused_err = err_inject;
   assign err_mask   = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= 3'd0;
         data_q  <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < NL; i++)
            lfsr_q[i] <= 31'h7FFFFFFF ^ 31'(i);
      end else begin
         state_q <= state_d;
         if (seed) mode_q <= mode;
         if (load) begin
            data_q <= word_d ^ err_mask;
            for (int i = 0; i < NL; i++)
               lfsr_q[i] <= lfsr_d[i];
         end
         if (seed)          cnt_q <= '0;
         else if (count_en) cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_prbs_multi_gen.sv
// Directed bench for prbs_multi_gen: two instances (8b x1 lane, 32b x4 lanes).
// Expected words come from a bit-history recurrence model b[n]=b[n-W]^b[n-T].
module tb_prbs_multi_gen;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]   a_mode, b_mode;
   logic         a_start, a_stop, a_err, a_ready, a_valid, a_busy;
   logic         b_start, b_stop, b_err, b_ready, b_valid, b_busy;
   logic [7:0]   a_data;
   logic [127:0] b_data;
   logic [31:0]  a_cnt, b_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   logic [63:0] flip_exp;

   prbs_multi_gen #(.DATA_WIDTH(8), .NUM_LANES(1), .COUNT_WIDTH(32)) u_a (
      .clk(clk), .rst(rst), .mode(a_mode), .start(a_start), .stop(a_stop),
      .err_inject(a_err), .out_valid(a_valid), .out_ready(a_ready),
      .data_out(a_data), .busy(a_busy), .word_count(a_cnt)
   );

   prbs_multi_gen #(.DATA_WIDTH(32), .NUM_LANES(4), .COUNT_WIDTH(32)) u_b (
      .clk(clk), .rst(rst), .mode(b_mode), .start(b_start), .stop(b_stop),
      .err_inject(b_err), .out_valid(b_valid), .out_ready(b_ready),
      .data_out(b_data), .busy(b_busy), .word_count(b_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] exp_word(int md, int lane, int dw, int k);
      int w, t;
      bit iv;
      bit hb [0:2047];
      logic [30:0] sd;
      logic [63:0] r;
      case (md)
         0: begin w = 7;  t = 6;  end
         1: begin w = 9;  t = 5;  end
         2: begin w = 15; t = 14; end
         3: begin w = 23; t = 18; end
         default: begin w = 31; t = 28; end
      endcase
      iv = (md >= 2);
      sd = 31'h7FFFFFFF ^ 31'(lane);
      for (int j = 0; j < w; j++) hb[j] = sd[w-1-j];
      for (int n = w; n < w + (k + 1) * dw; n++) hb[n] = hb[n-w] ^ hb[n-t];
      r = '0;
      for (int m = 0; m < dw; m++) r = {r[62:0], hb[w + k*dw + m] ^ iv};
      return r;
   endfunction

   initial begin
      rst = 1'b1;
      {a_mode, a_start, a_stop, a_err, a_ready} = '0;
      {b_mode, b_start, b_stop, b_err, b_ready} = '0;
      tick();
      tick();
      check("rst_a_valid", 64'(a_valid), 64'd0);
      check("rst_a_busy",  64'(a_busy),  64'd0);
      check("rst_a_cnt",   64'(a_cnt),   64'd0);
      check("rst_a_data",  64'(a_data),  64'd0);
      check("rst_b_data",  64'(b_data[63:0] | b_data[127:64]), 64'd0);
      rst = 1'b0;
      tick();

      // PRBS31, 4 lanes of 32 bits
      b_mode = 3'd4; b_ready = 1'b1; b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check("b_lanes_differ", 64'(b_data[31:0] == b_data[63:32]), 64'd0);
      for (int k = 0; k < 4; k++) begin
         for (int l = 0; l < 4; l++)
            check($sformatf("b_w%0d_l%0d", k, l),
                  64'(b_data[l*32 +: 32]), exp_word(4, l, 32, k));
         if (k == 3) b_stop = 1'b1;
         tick();
      end
      b_stop = 1'b0;
      check("b_stop_acc_valid", 64'(b_valid), 64'd0);
      check("b_stop_acc_cnt",   64'(b_cnt),   64'd4);

      // PRBS7 stream; mode change mid-run must be ignored
      a_mode = 3'd0; a_ready = 1'b1; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      a_mode  = 3'd3;
      check("a_first_word", 64'(a_data), 64'h02);
      check("a_busy_run",   64'(a_busy), 64'd1);
      for (int k = 0; k < 128; k++) begin
         check($sformatf("a_w%0d", k), 64'(a_data), exp_word(0, 0, 8, k));
         if (k % 16 == 0)
            check($sformatf("a_cnt%0d", k), 64'(a_cnt), 64'(k));
         if (k == 127) check("a_w127_eq_w0", 64'(a_data), 64'h02);
         tick();
      end

      // stall for 5 cycles
      a_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("stall_valid", 64'(a_valid), 64'd1);
         check("stall_data",  64'(a_data),  exp_word(0, 0, 8, 128));
         check("stall_cnt",   64'(a_cnt),   64'd128);
      end
      a_ready = 1'b1;
      for (int k = 128; k < 132; k++) begin
         check($sformatf("resume_w%0d", k), 64'(a_data), exp_word(0, 0, 8, k));
         tick();
      end

      // stop while stalled -> DRAIN
      a_ready = 1'b0; a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      check("drain_busy",  64'(a_busy),  64'd1);
      check("drain_valid", 64'(a_valid), 64'd1);
      tick();
      check("drain_data",  64'(a_data),  exp_word(0, 0, 8, 132));
      check("drain_cnt",   64'(a_cnt),   64'd132);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check("idle_valid", 64'(a_valid), 64'd0);
      check("idle_busy",  64'(a_busy),  64'd0);
      check("idle_cnt",   64'(a_cnt),   64'd133);
      check("idle_hold",  64'(a_data),  exp_word(0, 0, 8, 132));
      a_start = 1'b1; a_stop = 1'b1;
      tick();
      a_start = 1'b0; a_stop = 1'b0;
      check("ss_valid", 64'(a_valid), 64'd0);
      tick();
      check("ss_busy",  64'(a_busy),  64'd0);

      // PRBS15 (inverted), then stop on an accept cycle
      a_mode = 3'd2; a_start = 1'b1; a_ready = 1'b1;
      tick();
      a_start = 1'b0;
      check("p15_w0", 64'(a_data), exp_word(2, 0, 8, 0));
      tick();
      check("p15_w1", 64'(a_data), exp_word(2, 0, 8, 1));
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      check("stop_acc_valid", 64'(a_valid), 64'd0);

      // async reset mid-run
      a_mode = 3'd0; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      tick();
      tick();
      check("pre_rst_w2", 64'(a_data), exp_word(0, 0, 8, 2));
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 64'(a_valid), 64'd0);
      check("arst_busy",  64'(a_busy),  64'd0);
      check("arst_cnt",   64'(a_cnt),   64'd0);
      check("arst_data",  64'(a_data),  64'd0);
      tick();
      rst = 1'b0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("restart_w0",  64'(a_data), 64'h02);
      check("restart_cnt", 64'(a_cnt),  64'd0);

      // error injection while word 3 is stalled
      tick();
      tick();
      tick();
      a_ready = 1'b0; a_err = 1'b1;
      tick();
      a_err = 1'b0;
      tick();
      a_err = 1'b1;
      tick();
      a_err = 1'b0;
      check("inj_w3_held", 64'(a_data), exp_word(0, 0, 8, 3));
      a_ready = 1'b1;
      tick();
`ifdef PRBS_ERR_INJ_EN
      flip_exp = 64'h80;
`else
      flip_exp = 64'h00;
`endif
      check("inj_w4", 64'(a_data), exp_word(0, 0, 8, 4) ^ flip_exp);
      tick();
      check("inj_w5", 64'(a_data), exp_word(0, 0, 8, 5));
      tick();
      check("inj_w6", 64'(a_data), exp_word(0, 0, 8, 6));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
